// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the multicycle control sequencer: opcodes, IR field
// positions, FSM state encodings and the decoded-instruction record.
package cpu_ctrl_seq_pkg;

    // ALU class opcodes
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    // Control and immediate opcodes; every other value executes as NOP
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    typedef struct packed {
        logic is_alu;
        logic is_ldi;
        logic is_jmp;
        logic is_jz;
        logic is_hlt;
        logic imm_sel;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: classifies the instruction held in IR.
module instr_decode
    import cpu_ctrl_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    // NOTE: every output of a combinational block gets a default before the
    // case so that unlisted opcodes cannot infer a latch.
    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: dec.is_alu = 1'b1;
            OP_LDI: begin
                dec.is_ldi  = 1'b1;
                dec.imm_sel = 1'b1;
            end
            OP_JMP:  dec.is_jmp = 1'b1;
            OP_JZ:   dec.is_jz  = 1'b1;
            OP_HLT:  dec.is_hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multicycle FETCH/LOAD/EXEC/WB control sequencer: owns PC, IR and the
// retired-instruction counter and drives datapath selects and write enable.
module cpu_ctrl_seq
    import cpu_ctrl_seq_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    input  logic              rd_zero,
    output logic [1:0]        rd_sel,
    output logic [1:0]        rs_sel,
    output logic [7:0]        imm,
    output logic [3:0]        alu_op,
    output logic              imm_sel,
    output logic              rf_we,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNTW-1:0]   retired
);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q;
    logic              jz_take_q;
    logic [CNTW-1:0]   retired_q;
    dec_t              dec;

    instr_decode u_instr_decode (
        .opcode (ir_q[OP_MSB:OP_LSB]),
        .dec    (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_in) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_EXEC;
            S_EXEC:  state_d = dec.is_hlt ? S_HALT : S_WB;
            S_WB:    state_d = en_in ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Jump target is the 8-bit immediate zero-extended into the PC width
    always_comb begin
        pc_d = pc_q + AWIDTH'(1);
        if (dec.is_jmp || (dec.is_jz && jz_take_q))
            pc_d = AWIDTH'(ir_q[IMM_MSB:IMM_LSB]);
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            jz_take_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LOAD)
                ir_q <= rom_data;
            // Branch condition is frozen here so WB-time register changes are ignored
            if (state_q == S_EXEC)
                jz_take_q <= rd_zero;
            if (state_q == S_WB) begin
                pc_q      <= pc_d;
                retired_q <= retired_q + CNTW'(1);
            end
        end
    end

    assign rom_addr = pc_q;
    assign rd_sel   = ir_q[RD_MSB:RD_LSB];
    assign rs_sel   = ir_q[RS_MSB:RS_LSB];
    assign imm      = ir_q[IMM_MSB:IMM_LSB];
    assign alu_op   = ir_q[OP_MSB:OP_LSB];
    assign imm_sel  = dec.imm_sel;
    assign rf_we    = (state_q == S_WB) && (dec.is_alu || dec.is_ldi);
    assign halted   = (state_q == S_HALT);
    assign state    = state_q;
    assign retired  = retired_q;

endmodule
